binary_search_engine: RTL

- Self-contained binary search unit over a sorted, ascending, synchronous-read RAM of 2**ADDR_W words.
- Integrates the search controller and the bounds/midpoint datapath.
- Drives the RAM address directly, tolerates configurable RAM read latency, and reports found/not-found, match index or insertion point, and probe count.
- Sits between the top-level key/switch interface and the lab RAM instance.

---
 rtl/binary_search_engine.sv | 105 ++++++++++
 1 files changed

// File: rtl/binary_search_engine.sv
// binary_search_engine: binary search over a sorted, ascending, synchronous-read RAM
// with configurable read latency; reports found/index (or insertion point) and probe count.
module binary_search_engine #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int RD_LAT = 1,
  localparam int PW = $clog2(ADDR_W + 2)
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Start,
  input  logic [DATA_W-1:0] A,
  output logic [ADDR_W-1:0] Ram_Addr,
  input  logic [DATA_W-1:0] Ram_Data,
  output logic              Busy,
  output logic              Done,
  output logic              Found,
  output logic [ADDR_W:0]   Index,
  output logic [PW-1:0]     Probes
);
  localparam int SW = ADDR_W + 2;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int LW = $clog2(RD_LAT) + 1;
  typedef enum logic [1:0] {IDLE, PROBE, CMP, DONE} state_t;
  state_t state_q, state_d;
  logic signed [SW-1:0] l_q, l_d, r_q, r_d, mid;
  logic signed [SW:0] sum;
  logic [DATA_W-1:0] key_q, key_d;
  logic [LW-1:0] lat_q, lat_d;
  logic found_q, found_d;
  logic [ADDR_W:0] index_q, index_d;
  logic [PW-1:0] probes_q, probes_d;
  // one spare bit keeps L+R from wrapping before the arithmetic halve
  assign sum = (SW+1)'(l_q) + (SW+1)'(r_q);
  assign mid = SW'(sum >>> 1);
  assign Ram_Addr = mid[ADDR_W-1:0];
  assign Busy = (state_q == PROBE) || (state_q == CMP);
  assign Done = state_q == DONE;
  assign Found = found_q;
  assign Index = index_q;
  assign Probes = probes_q;
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q  <= IDLE;
      l_q      <= '0;
      r_q      <= SW'(DEPTH - 1);
      key_q    <= '0;
      lat_q    <= '0;
      found_q  <= 1'b0;
      index_q  <= '0;
      probes_q <= '0;
    end else begin
      state_q  <= state_d;
      l_q      <= l_d;
      r_q      <= r_d;
      key_q    <= key_d;
      lat_q    <= lat_d;
      found_q  <= found_d;
      index_q  <= index_d;
      probes_q <= probes_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    l_d      = l_q;
    r_d      = r_q;
    key_d    = key_q;
    lat_d    = lat_q;
    found_d  = found_q;
    index_d  = index_q;
    probes_d = probes_q;
    case (state_q)
      IDLE: if (Start) begin
        key_d    = A;
        l_d      = '0;
        r_d      = SW'(DEPTH - 1);
        probes_d = '0;
        lat_d    = '0;
        found_d  = 1'b0;
        index_d  = '0;
        state_d  = PROBE;
      end
      PROBE: begin
        lat_d   = (lat_q == LW'(RD_LAT - 1)) ? '0 : lat_q + 1'b1;
        state_d = (lat_q == LW'(RD_LAT - 1)) ? CMP : PROBE;
      end
      CMP: begin
        probes_d = probes_q + 1'b1;
        if (key_q == Ram_Data) begin
          found_d = 1'b1;
          index_d = mid[ADDR_W:0];
          state_d = DONE;
        end else begin
          l_d = (key_q > Ram_Data) ? mid + SW'(1) : l_q;
          r_d = (key_q < Ram_Data) ? mid - SW'(1) : r_q;
          // crossed bounds: L is where the key would be inserted
          index_d = (l_d > r_d) ? l_d[ADDR_W:0] : index_q;
          state_d = (l_d > r_d) ? DONE : PROBE;
        end
      end
      DONE: state_d = Start ? DONE : IDLE;
      default: state_d = IDLE;
    endcase
  end
endmodule
